// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types and constants for the BCD timer.
//   state_t  - controller states (IDLE=0, RUN=1, EDIT=2)
//   event_t  - the single button event accepted in a cycle
//   BCD_MAX  - largest decimal digit value
//   pick_event() - priority encoder clear > start_stop > set > change > lap
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EDIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLEAR,
        EV_START,
        EV_SET,
        EV_CHANGE,
        EV_LAP
    } event_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Only the highest-priority pulse of a cycle survives, even if the
    // current state then ignores it.
    function automatic event_t pick_event(input logic clr, input logic ss,
                                          input logic set, input logic chg,
                                          input logic lap);
        if (clr)      return EV_CLEAR;
        else if (ss)  return EV_START;
        else if (set) return EV_SET;
        else if (chg) return EV_CHANGE;
        else if (lap) return EV_LAP;
        else          return EV_NONE;
    endfunction

endpackage

// File: rtl/bcd_timer_digit.sv
// bcd_timer_digit: one BCD decade of the timer count.
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_clear         - load zero (highest priority)
//   i_edit_inc      - +1 mod 10 without producing a carry
//   i_carry_in      - ripple increment request from the lower decade
//   i_borrow_in     - ripple decrement request from the lower decade
//   o_digit         - current decade value
//   o_carry_out     - increment wraps 9 -> 0
//   o_borrow_out    - decrement wraps 0 -> 9
module bcd_timer_digit
    import bcd_timer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_edit_inc,
    input  logic       i_carry_in,
    input  logic       i_borrow_in,
    output logic [3:0] o_digit,
    output logic       o_carry_out,
    output logic       o_borrow_out
);

    logic [3:0] r_digit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digit <= '0;
        end else if (i_clear) begin
            r_digit <= '0;
        end else if (i_edit_inc || i_carry_in) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end else if (i_borrow_in) begin
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    assign o_digit      = r_digit;
    assign o_carry_out  = i_carry_in && (r_digit == BCD_MAX);
    assign o_borrow_out = i_borrow_in && (r_digit == 4'd0);

endmodule

// File: rtl/bcd_timer.sv
// bcd_timer: DIGITS-wide BCD up/down timer with lap freeze and digit edit.
//   clk100_i, rstn_i       - clock, asynchronous active-low reset
//   start_stop_i, set_i, change_i, lap_i, clear_i - single-cycle press pulses
//   count_down_i           - 1 = countdown, sampled when a run starts
//   digits_o               - displayed BCD value (lap register when frozen)
//   running_o, edit_en_o   - state indicators
//   edit_digit_o           - selected digit while editing, else 0
//   lap_active_o           - display frozen
//   alarm_o, overflow_o    - one-cycle pulses: countdown hit 0 / up-count wrapped
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned PULSE_MAX = 999999
) (
    input  logic                  clk100_i,
    input  logic                  rstn_i,
    input  logic                  start_stop_i,
    input  logic                  set_i,
    input  logic                  change_i,
    input  logic                  lap_i,
    input  logic                  clear_i,
    input  logic                  count_down_i,
    output logic [4*DIGITS-1:0]   digits_o,
    output logic                  running_o,
    output logic                  edit_en_o,
    output logic [2:0]            edit_digit_o,
    output logic                  lap_active_o,
    output logic                  alarm_o,
    output logic                  overflow_o
);

    localparam logic [2:0]          LAST_IDX  = 3'(DIGITS - 1);
    localparam logic [19:0]         PRESC_MAX = 20'(PULSE_MAX);
    localparam logic [4*DIGITS-1:0] COUNT_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

    state_t                r_state, w_state_next;
    event_t                w_event;
    logic [19:0]           r_presc;
    logic                  r_mode_down;
    logic                  r_lap_active;
    logic [4*DIGITS-1:0]   r_lap;
    logic [2:0]            r_edit_idx;
    logic                  r_alarm, r_overflow;

    logic [4*DIGITS-1:0]   w_count;
    logic [DIGITS:0]       w_carry, w_borrow;
    logic [DIGITS-1:0]     w_edit_inc;
    logic                  w_tick, w_alarm;
    logic                  w_start, w_clear, w_enter_edit, w_edit_adv;
    logic                  w_edit_change, w_lap_toggle, w_lap_off;

    assign w_event = pick_event(clear_i, start_stop_i, set_i, change_i, lap_i);

    // A stop press holds the prescaler, so no tick is taken that cycle.
    assign w_tick      = (r_state == ST_RUN) && (r_presc == PRESC_MAX) && (w_event != EV_START);
    assign w_carry[0]  = w_tick && !r_mode_down;
    assign w_borrow[0] = w_tick && r_mode_down;
    // Top-level borrow would mean decrementing from zero; treated as alarm too.
    assign w_alarm     = w_borrow[0] && ((w_count == COUNT_ONE) || w_borrow[DIGITS]);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign w_edit_inc[k] = w_edit_change && (r_edit_idx == 3'(k));
        bcd_timer_digit u_digit (
            .i_clk        (clk100_i),
            .i_rst_n      (rstn_i),
            .i_clear      (w_clear),
            .i_edit_inc   (w_edit_inc[k]),
            .i_carry_in   (w_carry[k]),
            .i_borrow_in  (w_borrow[k]),
            .o_digit      (w_count[4*k +: 4]),
            .o_carry_out  (w_carry[k+1]),
            .o_borrow_out (w_borrow[k+1])
        );
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_clear       = 1'b0;
        w_enter_edit  = 1'b0;
        w_edit_adv    = 1'b0;
        w_edit_change = 1'b0;
        w_lap_toggle  = 1'b0;
        w_lap_off     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case (w_event)
                    EV_CLEAR: w_clear = 1'b1;
                    EV_START: begin
                        if (!(count_down_i && (w_count == '0))) begin
                            w_state_next = ST_RUN;
                            w_start      = 1'b1;
                        end
                    end
                    EV_SET: begin
                        w_state_next = ST_EDIT;
                        w_enter_edit = 1'b1;
                    end
                    EV_LAP:  w_lap_off = 1'b1;
                    default: ;
                endcase
            end
            ST_RUN: begin
                if (w_event == EV_START)    w_state_next = ST_IDLE;
                else if (w_alarm)           w_state_next = ST_IDLE;
                if (w_event == EV_LAP)      w_lap_toggle = 1'b1;
            end
            ST_EDIT: begin
                if (w_event == EV_SET) begin
                    w_edit_adv = 1'b1;
                    if (r_edit_idx == LAST_IDX) w_state_next = ST_IDLE;
                end else if (w_event == EV_CHANGE) begin
                    w_edit_change = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_presc      <= '0;
            r_mode_down  <= 1'b0;
            r_lap_active <= 1'b0;
            r_lap        <= '0;
            r_edit_idx   <= '0;
            r_alarm      <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_alarm    <= w_alarm;
            r_overflow <= w_carry[DIGITS];

            if (w_clear) begin
                r_presc <= '0;
            end else if ((r_state == ST_RUN) && (w_event != EV_START)) begin
                r_presc <= (r_presc == PRESC_MAX) ? 20'd0 : r_presc + 20'd1;
            end

            if (w_start) r_mode_down <= count_down_i;

            if (w_clear || w_lap_off || w_enter_edit) begin
                r_lap_active <= 1'b0;
            end else if (w_lap_toggle) begin
                r_lap_active <= !r_lap_active;
                if (!r_lap_active) r_lap <= w_count;
            end

            if (w_enter_edit) begin
                r_edit_idx <= '0;
            end else if (w_edit_adv) begin
                r_edit_idx <= (r_edit_idx == LAST_IDX) ? 3'd0 : r_edit_idx + 3'd1;
            end
        end
    end

    assign digits_o     = r_lap_active ? r_lap : w_count;
    assign running_o    = (r_state == ST_RUN);
    assign edit_en_o    = (r_state == ST_EDIT);
    assign edit_digit_o = (r_state == ST_EDIT) ? r_edit_idx : 3'd0;
    assign lap_active_o = r_lap_active;
    assign alarm_o      = r_alarm;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_bcd_timer.sv
module tb_bcd_timer;

    localparam logic [4:0] P_CLR = 5'b10000;
    localparam logic [4:0] P_SS  = 5'b01000;
    localparam logic [4:0] P_SET = 5'b00100;
    localparam logic [4:0] P_CHG = 5'b00010;
    localparam logic [4:0] P_LAP = 5'b00001;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ss, set, chg, lap, clr, cd;
    logic [15:0] digits;
    logic        running, edit_en, lap_active, alarm, overflow;
    logic [2:0]  edit_digit;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    bcd_timer #(.DIGITS(4), .PULSE_MAX(3)) dut (
        .clk100_i     (clk),
        .rstn_i       (rstn),
        .start_stop_i (ss),
        .set_i        (set),
        .change_i     (chg),
        .lap_i        (lap),
        .clear_i      (clr),
        .count_down_i (cd),
        .digits_o     (digits),
        .running_o    (running),
        .edit_en_o    (edit_en),
        .edit_digit_o (edit_digit),
        .lap_active_o (lap_active),
        .alarm_o      (alarm),
        .overflow_o   (overflow)
    );

    typedef struct {
        logic [4:0]  ev;
        logic [15:0] digits;
        logic        run;
        logic        edit;
        logic [2:0]  idx;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive a pulse pattern for exactly one rising edge; returns at the next negedge.
    task automatic pulse(input logic [4:0] ev);
        {clr, ss, set, chg, lap} = ev;
        @(negedge clk);
        {clr, ss, set, chg, lap} = '0;
    endtask

    task automatic pulses(input logic [4:0] ev, input int n);
        for (int i = 0; i < n; i++) pulse(ev);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h00, digits, running, edit_en, edit_digit, lap_active, alarm, overflow};
    endfunction

    initial begin
        logic seen;
        logic bad;

        // Edit sequence with ignored and conflicting pulses.
        tbl[0]  = '{P_SET,         16'h0000, 1'b0, 1'b1, 3'd0};
        tbl[1]  = '{P_CHG,         16'h0001, 1'b0, 1'b1, 3'd0};
        tbl[2]  = '{P_CHG,         16'h0002, 1'b0, 1'b1, 3'd0};
        tbl[3]  = '{P_SS,          16'h0002, 1'b0, 1'b1, 3'd0};
        tbl[4]  = '{P_CLR | P_CHG, 16'h0002, 1'b0, 1'b1, 3'd0};
        tbl[5]  = '{P_SET | P_CHG, 16'h0002, 1'b0, 1'b1, 3'd1};
        tbl[6]  = '{P_CHG,         16'h0012, 1'b0, 1'b1, 3'd1};
        tbl[7]  = '{P_CHG,         16'h0022, 1'b0, 1'b1, 3'd1};
        tbl[8]  = '{P_CHG,         16'h0032, 1'b0, 1'b1, 3'd1};
        tbl[9]  = '{P_CHG,         16'h0042, 1'b0, 1'b1, 3'd1};
        tbl[10] = '{P_LAP,         16'h0042, 1'b0, 1'b1, 3'd1};
        tbl[11] = '{P_SET,         16'h0042, 1'b0, 1'b1, 3'd2};
        tbl[12] = '{P_SET,         16'h0042, 1'b0, 1'b1, 3'd3};
        tbl[13] = '{P_SET,         16'h0042, 1'b0, 1'b0, 3'd0};
        tbl[14] = '{P_SS | P_CLR,  16'h0000, 1'b0, 1'b0, 3'd0};

        rstn = 1'b0;
        {clr, ss, set, chg, lap} = '0;
        cd = 1'b0;
        wait_clk(3);
        check("reset_outputs", all_outs(), 32'h0);
        rstn = 1'b1;
        wait_clk(1);

        for (int i = 0; i < 15; i++) begin
            pulse(tbl[i].ev);
            check($sformatf("table_row_%0d", i),
                  {11'h0, digits, running, edit_en, edit_digit},
                  {11'h0, tbl[i].digits, tbl[i].run, tbl[i].edit, tbl[i].idx});
        end

        // Up count: 40 clocks at 4 clocks per tick.
        pulse(P_SS);
        wait_clk(40);
        check("up40_digits", 32'(digits), 32'h0010);
        check("up40_running", 32'(running), 32'h1);
        pulse(P_SS);
        check("stop_running", 32'(running), 32'h0);
        wait_clk(5);
        check("stop_holds", 32'(digits), 32'h0010);

        // Load 9998 through edit, then overflow.
        pulse(P_CLR);
        pulse(P_SET);
        pulses(P_CHG, 8);
        pulse(P_SET);
        pulses(P_CHG, 9);
        pulse(P_SET);
        pulses(P_CHG, 9);
        pulse(P_SET);
        pulses(P_CHG, 9);
        check("edit_9998", {13'h0, digits, edit_digit}, {13'h0, 16'h9998, 3'd3});
        pulse(P_SET);
        check("edit_exit", 32'(edit_en), 32'h0);
        pulse(P_SS);
        wait_clk(7);
        check("pre_wrap", {15'h0, digits, overflow}, {15'h0, 16'h9999, 1'b0});
        wait_clk(1);
        check("wrap", {14'h0, digits, overflow, running}, {14'h0, 16'h0000, 1'b1, 1'b1});
        wait_clk(1);
        check("overflow_one_cycle", 32'(overflow), 32'h0);

        // Countdown from 0002.
        pulse(P_SS);
        pulse(P_CLR);
        pulse(P_SET);
        pulses(P_CHG, 2);
        pulses(P_SET, 4);
        check("load_0002", {15'h0, digits, edit_en}, {15'h0, 16'h0002, 1'b0});
        cd = 1'b1;
        pulse(P_SS);
        check("down_running", 32'(running), 32'h1);
        wait_clk(7);
        check("down_0001", {15'h0, digits, alarm}, {15'h0, 16'h0001, 1'b0});
        wait_clk(1);
        check("alarm", {14'h0, digits, alarm, running}, {14'h0, 16'h0000, 1'b1, 1'b0});
        wait_clk(1);
        check("alarm_one_cycle", 32'(alarm), 32'h0);

        // Down start at zero is refused.
        pulse(P_SS);
        check("zero_down_start", 32'(running), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_clk(1);
            if (alarm) seen = 1'b1;
        end
        check("zero_down_no_alarm", 32'(seen), 32'h0);

        // Lap freeze at 0005.
        cd = 1'b0;
        pulse(P_SET);
        pulses(P_CHG, 5);
        pulses(P_SET, 4);
        pulse(P_SS);
        pulse(P_LAP);
        check("lap_freeze", {15'h0, digits, lap_active}, {15'h0, 16'h0005, 1'b1});
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_clk(1);
            if (digits !== 16'h0005) bad = 1'b1;
        end
        check("lap_held_20", 32'(bad), 32'h0);
        pulse(P_LAP);
        check("lap_release", {15'h0, digits, lap_active}, {15'h0, 16'h0010, 1'b0});

        // Asynchronous reset while running with freeze on.
        pulse(P_LAP);
        check("lap_again", {14'h0, lap_active, running}, {14'h0, 1'b1, 1'b1});
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", all_outs(), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        wait_clk(2);
        check("after_reset", all_outs(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
